// File: rtl/rom_pkg.sv
// Shared definitions for the rom_stream lookup ROM.
//   - FSM state encoding for the scan sequencer
//   - default geometry and table-generation constants
//   - wrap_step(): +/-1 address step modulo an arbitrary depth
package rom_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } state_e;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_INIT_BASE = 0;
  localparam int unsigned DEF_INIT_STEP = 2;

  // Next address in a run. The wrap is explicit because depth need not be a power of two.
  function automatic int unsigned wrap_step(int unsigned addr, logic dir, int unsigned depth);
    if (dir) begin
      return (addr == 0) ? depth - 1 : addr - 1;
    end
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/rom_core.sv
// Storage array for rom_stream with an enabled, registered read port.
// Contents are fixed at elaboration: mem[i] = (INIT_BASE + INIT_STEP*i) mod 2^WIDTH.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears the read register)
//   en     in   load the read register this cycle
//   addr   in   read address; addresses >= DEPTH read as zero
//   data   out  registered read data
module rom_core import rom_pkg::*; #(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned INIT_BASE = DEF_INIT_BASE,
  parameter int unsigned INIT_STEP = DEF_INIT_STEP,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;
  logic [WIDTH-1:0] rd_word;

  for (genvar i = 0; i < DEPTH; i++) begin : g_init
    assign mem[i] = WIDTH'(INIT_BASE + INIT_STEP * i);
  end

  assign in_range = 32'(addr) < DEPTH;
  assign rd_word  = in_range ? mem[addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= rd_word;
    end
  end

endmodule

// File: rtl/rom_stream.sv
// Lookup ROM with a valid/ready read port and a built-in address sequencer.
// Serves single random reads or streams a contiguous run of words (up/down, wrapping).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rd_req, rd_addr    random-read request/address; accepted when rd_req && rd_gnt
//   rd_gnt             combinational grant: idle, output free and no scan_start
//   scan_start         start a run (idle only); scan_base/scan_len/scan_dir describe it
//   scan_len           0 or > DEPTH means DEPTH words
//   scan_abort         terminate a run in progress
//   data, data_vld     registered output word and valid
//   data_rdy           consumer ready
//   data_last          final word of a run
//   err                one-cycle pulse for an out-of-range read or scan base
//   busy               sequencer not idle
module rom_stream import rom_pkg::*; #(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned INIT_BASE = DEF_INIT_BASE,
  parameter int unsigned INIT_STEP = DEF_INIT_STEP,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  input  logic             scan_start,
  input  logic [AW-1:0]    scan_base,
  input  logic [AW:0]      scan_len,
  input  logic             scan_dir,
  input  logic             scan_abort,
  output logic [WIDTH-1:0] data,
  output logic             data_vld,
  input  logic             data_rdy,
  output logic             data_last,
  output logic             err,
  output logic             busy
);

  localparam logic [AW:0] LEN_MAX = DEPTH[AW:0];
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;     // words still to emit after the current one
  logic          dir_q, dir_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic          free;
  logic          base_ok;
  logic          rd_ok;
  logic [AW:0]   len_eff;
  logic [AW-1:0] step_src;
  logic          step_dir;
  logic [AW-1:0] step_addr;
  logic          gnt;
  logic          core_en;
  logic [AW-1:0] core_addr;

  assign free    = !vld_q || data_rdy;
  assign base_ok = 32'(scan_base) < DEPTH;
  assign rd_ok   = 32'(rd_addr) < DEPTH;

  always_comb begin
    if (scan_len == '0 || 32'(scan_len) > DEPTH) begin
      len_eff = LEN_MAX;
    end else begin
      len_eff = scan_len;
    end
  end

  // In idle the step is taken from the incoming base so the second word is ready next cycle.
  always_comb begin
    if (state_q == StIdle) begin
      step_src = scan_base;
      step_dir = scan_dir;
    end else begin
      step_src = addr_q;
      step_dir = dir_q;
    end
    step_addr = AW'(wrap_step(32'(step_src), step_dir, DEPTH));
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    vld_d     = vld_q;
    last_d    = last_q;
    err_d     = 1'b0;
    gnt       = 1'b0;
    core_en   = 1'b0;
    core_addr = addr_q;

    case (state_q)
      StIdle: begin
        if (free) begin
          // Whatever was on the output has been taken; empty unless refilled below.
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (scan_start) begin
            if (base_ok) begin
              core_en   = 1'b1;
              core_addr = scan_base;
              vld_d     = 1'b1;
              dir_d     = scan_dir;
              addr_d    = step_addr;
              cnt_d     = len_eff - LEN_ONE;
              if (len_eff == LEN_ONE) begin
                last_d  = 1'b1;
                state_d = StDrain;
              end else begin
                state_d = StScan;
              end
            end else begin
              err_d = 1'b1;
            end
          end else begin
            gnt = 1'b1;
            if (rd_req) begin
              core_en   = 1'b1;
              core_addr = rd_addr;
              vld_d     = 1'b1;
              err_d     = !rd_ok;
            end
          end
        end
      end

      StScan: begin
        if (scan_abort) begin
          state_d = StIdle;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (free) begin
          core_en = 1'b1;
          vld_d   = 1'b1;
          addr_d  = step_addr;
          cnt_d   = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            last_d  = 1'b1;
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (scan_abort) begin
          state_d = StIdle;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (free) begin
          state_d = StIdle;
          vld_d   = 1'b0;
          last_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  rom_core #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .INIT_BASE(INIT_BASE),
    .INIT_STEP(INIT_STEP)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (core_en),
    .addr (core_addr),
    .data (data)
  );

  // Gated by reset so the grant reads 0 while the block is held in reset.
  assign rd_gnt    = rst_n && gnt;
  assign data_vld  = vld_q;
  assign data_last = last_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);

endmodule
